intr_service_initiator: RTL and testbench

Processor-side counterpart of the APB-programmable interrupt controller. It drives the controller's APB port as initiator, loading all per-peripheral priority registers from a packed table at boot. It then answers the interrupt handshake: it takes `intr_valid`/`intr_to_service`, reads back the winning peripheral's priority over APB, and models a fixed-length service routine. On completion it pulses `intr_serviced` plus a one-hot acknowledge to the peripheral.

---
 rtl/intr_service_initiator_if.sv | 31 +++
 rtl/intr_service_initiator.sv | 168 ++++++++++++++++
 tb/tb_intr_service_initiator.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_service_initiator_if.sv
// Purpose: APB initiator bus plus interrupt handshake between the service initiator and the controller.
// Latency: pure wiring, none added.
// Backpressure: APB transfers are held by penable_o until pready_i; intr_valid_i stays up until serviced.
interface intr_service_initiator_if #(
    parameter int NUM_PERIPHS  = 16,
    parameter int PERIPH_INDEX = $clog2(NUM_PERIPHS)
);
    logic [PERIPH_INDEX-1:0] paddr_o;
    logic                    pwrite_o;
    logic [PERIPH_INDEX-1:0] pwdata_o;
    logic                    penable_o;
    logic [PERIPH_INDEX-1:0] prdata_i;
    logic                    pready_i;
    logic                    perror_i;
    logic                    intr_valid_i;
    logic [PERIPH_INDEX-1:0] intr_to_service_i;
    logic                    intr_serviced_o;
    logic [NUM_PERIPHS-1:0]  intr_ack_o;

    // Initiator side: the service block drives the APB request and the service acknowledge.
    modport master (
        output paddr_o, pwrite_o, pwdata_o, penable_o, intr_serviced_o, intr_ack_o,
        input  prdata_i, pready_i, perror_i, intr_valid_i, intr_to_service_i
    );

    // Controller side: APB responder plus interrupt presenter.
    modport slave (
        input  paddr_o, pwrite_o, pwdata_o, penable_o, intr_serviced_o, intr_ack_o,
        output prdata_i, pready_i, perror_i, intr_valid_i, intr_to_service_i
    );
endinterface

// File: rtl/intr_service_initiator.sv
// Purpose: programs the interrupt controller's priority table over APB, then services presented interrupts.
// Latency: write 2 cycles + 1 gap with a one-wait responder; serviced pulse SERVICE_CYCLES after read-back.
// Backpressure: penable_o held until pready_i or APB_TIMEOUT cycles; a stale intr_valid_i is drained before re-arming.
module intr_service_initiator #(
    parameter int NUM_PERIPHS    = 16,
    parameter int PERIPH_INDEX   = $clog2(NUM_PERIPHS),
    parameter int SERVICE_CYCLES = 4,
    parameter int APB_TIMEOUT    = 15
) (
    input  logic                                pclk_i,
    input  logic                                prst_i,
    intr_service_initiator_if.master            bus,
    input  logic                                cfg_start_i,
    input  logic [NUM_PERIPHS*PERIPH_INDEX-1:0] cfg_prio_i,
    output logic                                cfg_done_o,
    output logic [PERIPH_INDEX-1:0]             last_intr_o,
    output logic [PERIPH_INDEX-1:0]             last_prio_o,
    output logic [15:0]                         svc_count_o,
    output logic                                err_o
);
    localparam int TMR_W = $clog2(SERVICE_CYCLES + 1);
    localparam int TMO_W = $clog2(APB_TIMEOUT + 1);
    localparam logic [PERIPH_INDEX-1:0] LAST_IDX = PERIPH_INDEX'(NUM_PERIPHS - 1);
    localparam logic [TMR_W-1:0]        SVC_LOAD = TMR_W'(SERVICE_CYCLES);
    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(APB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_WR,
        S_CFG_GAP,
        S_WAIT_INTR,
        S_RD_PRIO,
        S_SERVICE,
        S_DRAIN
    } state_t;

    state_t                  state;
    logic [PERIPH_INDEX-1:0] idx;
    logic [TMR_W-1:0]        svc_tmr;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    apb_tmo;
    logic                    cfg_go;
    logic [PERIPH_INDEX-1:0] prio_slot;

    // Transfer has been open for APB_TIMEOUT cycles and the responder is still silent.
    assign apb_tmo = !bus.pready_i && (tmo_cnt == TMO_LAST);

    // Table (re)start: an interrupt presented in the same cycle takes precedence and the start is dropped.
    assign cfg_go = cfg_start_i &&
                    ((state == S_IDLE) || ((state == S_WAIT_INTR) && !bus.intr_valid_i));

    // Priority slice for the register about to be written (idx already advanced in the gap cycle).
    always_comb begin
        prio_slot = cfg_prio_i[int'(idx)*PERIPH_INDEX +: PERIPH_INDEX];
    end

    // Main sequencer: APB initiator, service dwell timer and all registered status outputs.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state               <= S_IDLE;
            idx                 <= '0;
            svc_tmr             <= '0;
            tmo_cnt             <= '0;
            bus.paddr_o         <= '0;
            bus.pwrite_o        <= 1'b0;
            bus.pwdata_o        <= '0;
            bus.penable_o       <= 1'b0;
            bus.intr_serviced_o <= 1'b0;
            bus.intr_ack_o      <= '0;
            cfg_done_o          <= 1'b0;
            last_intr_o         <= '0;
            last_prio_o         <= '0;
            svc_count_o         <= '0;
            err_o               <= 1'b0;
        end else begin
            bus.intr_serviced_o <= 1'b0;
            bus.intr_ack_o      <= '0;
            if (cfg_go) begin
                err_o         <= 1'b0;
                cfg_done_o    <= 1'b0;
                idx           <= '0;
                tmo_cnt       <= '0;
                bus.penable_o <= 1'b1;
                bus.pwrite_o  <= 1'b1;
                bus.paddr_o   <= '0;
                bus.pwdata_o  <= cfg_prio_i[PERIPH_INDEX-1:0];
                state         <= S_CFG_WR;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_CFG_WR: begin
                        if (bus.pready_i || apb_tmo) begin
                            // A timed-out write counts as done so the table walk never stalls.
                            err_o         <= bus.pready_i ? (err_o | bus.perror_i) : 1'b1;
                            bus.penable_o <= 1'b0;
                            tmo_cnt       <= '0;
                            if (idx == LAST_IDX) begin
                                cfg_done_o <= 1'b1;
                                state      <= S_WAIT_INTR;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_CFG_GAP;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_CFG_GAP: begin
                        bus.penable_o <= 1'b1;
                        bus.paddr_o   <= idx;
                        bus.pwdata_o  <= prio_slot;
                        state         <= S_CFG_WR;
                    end
                    S_WAIT_INTR: begin
                        if (bus.intr_valid_i) begin
                            last_intr_o   <= bus.intr_to_service_i;
                            bus.penable_o <= 1'b1;
                            bus.pwrite_o  <= 1'b0;
                            bus.paddr_o   <= bus.intr_to_service_i;
                            tmo_cnt       <= '0;
                            state         <= S_RD_PRIO;
                        end
                    end
                    S_RD_PRIO: begin
                        if (bus.pready_i || apb_tmo) begin
                            // A timed-out read reports priority 0 and still runs the service routine.
                            if (bus.pready_i) begin
                                last_prio_o <= bus.prdata_i;
                                err_o       <= err_o | bus.perror_i;
                            end else begin
                                last_prio_o <= '0;
                                err_o       <= 1'b1;
                            end
                            bus.penable_o <= 1'b0;
                            tmo_cnt       <= '0;
                            svc_tmr       <= SVC_LOAD;
                            state         <= S_SERVICE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_SERVICE: begin
                        if (svc_tmr <= TMR_W'(1)) begin
                            svc_tmr             <= '0;
                            bus.intr_serviced_o <= 1'b1;
                            bus.intr_ack_o      <= NUM_PERIPHS'(1) << last_intr_o;
                            svc_count_o         <= svc_count_o + 16'd1;
                            state               <= S_DRAIN;
                        end else begin
                            svc_tmr <= svc_tmr - 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        // The controller's valid for the serviced interrupt must fall before re-arming.
                        if (!bus.intr_valid_i) begin
                            state <= S_WAIT_INTR;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_intr_service_initiator.sv
// Bench for intr_service_initiator: APB responder model, transfer/acknowledge monitor, scenario tasks.
// Expected transfers and acknowledges are queued when stimulus is driven and compared against observations.
module tb_intr_service_initiator;
    localparam int NP = 16;
    localparam int PI = 4;
    localparam int SC = 4;
    localparam int TO = 15;

    logic             pclk_i = 1'b0;
    logic             prst_i;
    logic             cfg_start_i;
    logic [NP*PI-1:0] cfg_prio_i;
    logic             cfg_done_o;
    logic [PI-1:0]    last_intr_o;
    logic [PI-1:0]    last_prio_o;
    logic [15:0]      svc_count_o;
    logic             err_o;

    intr_service_initiator_if #(.NUM_PERIPHS(NP), .PERIPH_INDEX(PI)) bus ();

    intr_service_initiator #(
        .NUM_PERIPHS(NP), .PERIPH_INDEX(PI), .SERVICE_CYCLES(SC), .APB_TIMEOUT(TO)
    ) dut (
        .pclk_i      (pclk_i),
        .prst_i      (prst_i),
        .bus         (bus.master),
        .cfg_start_i (cfg_start_i),
        .cfg_prio_i  (cfg_prio_i),
        .cfg_done_o  (cfg_done_o),
        .last_intr_o (last_intr_o),
        .last_prio_o (last_prio_o),
        .svc_count_o (svc_count_o),
        .err_o       (err_o)
    );

    always #5 pclk_i = ~pclk_i;

    int tests = 0;
    int fails = 0;

    logic          hang = 1'b0;
    logic          seen = 1'b0;
    logic [PI-1:0] mem [NP];

    logic [2*PI:0] exp_q [$];
    logic [2*PI:0] obs_q [$];
    logic [NP-1:0] exp_ack_q [$];
    logic [NP-1:0] ack_q [$];

    // Responder: pready one cycle after penable is seen, stores writes, answers reads; hangs while 'hang'.
    initial begin
        bus.pready_i = 1'b0;
        bus.perror_i = 1'b0;
        bus.prdata_i = '0;
        forever begin
            @(posedge pclk_i);
            #1;
            if (!prst_i || bus.pready_i) begin
                bus.pready_i = 1'b0;
            end else if (bus.penable_o && seen && !hang) begin
                bus.pready_i = 1'b1;
                if (bus.pwrite_o) mem[bus.paddr_o] = bus.pwdata_o;
                else              bus.prdata_i = mem[bus.paddr_o];
            end
            seen = prst_i && bus.penable_o;
        end
    end

    // Monitor: records every completed transfer and every serviced acknowledge.
    initial begin
        forever begin
            @(negedge pclk_i);
            if (prst_i && bus.penable_o && bus.pready_i)
                obs_q.push_back({bus.pwrite_o, bus.paddr_o, bus.pwrite_o ? bus.pwdata_o : bus.prdata_i});
            if (bus.intr_serviced_o) ack_q.push_back(bus.intr_ack_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        prst_i = 1'b1;
        cfg_start_i = 1'b0;
        cfg_prio_i = '0;
        bus.intr_valid_i = 1'b0;
        bus.intr_to_service_i = '0;
        #2 prst_i = 1'b0;
        repeat (3) @(negedge pclk_i);
        tests++;
        if ({bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o} !== '0) begin
            fails++;
            $display("FAIL reset_apb: got %0h want 0", {bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o});
        end
        tests++;
        if ({bus.intr_serviced_o, bus.intr_ack_o} !== '0) begin
            fails++;
            $display("FAIL reset_intr: got %0h want 0", {bus.intr_serviced_o, bus.intr_ack_o});
        end
        tests++;
        if ({cfg_done_o, last_intr_o, last_prio_o, svc_count_o, err_o} !== '0) begin
            fails++;
            $display("FAIL reset_status: got %0h want 0", {cfg_done_o, last_intr_o, last_prio_o, svc_count_o, err_o});
        end
        prst_i = 1'b1;
        bus.intr_valid_i = 1'b1;
        repeat (5) @(negedge pclk_i);
        tests++;
        if (bus.penable_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores_intr: penable got %b want 0", bus.penable_o);
        end
        bus.intr_valid_i = 1'b0;
    endtask

    // One full table pass with slot k = 15-k; optionally the first write never gets pready.
    task automatic cfg_pass(input string name, input bit hang_first);
        int cyc;
        int hi;
        int first_hi;
        logic [2*PI:0] e;
        logic [2*PI:0] o;
        for (int k = 0; k < NP; k++) begin
            cfg_prio_i[k*PI +: PI] = PI'(NP - 1 - k);
            if (!(hang_first && k == 0)) exp_q.push_back({1'b1, PI'(k), PI'(NP - 1 - k)});
        end
        hang = hang_first;
        @(negedge pclk_i);
        cfg_start_i = 1'b1;
        @(negedge pclk_i);
        cfg_start_i = 1'b0;
        tests++;
        if ({cfg_done_o, err_o, bus.penable_o, bus.pwrite_o} !== 4'b0011) begin
            fails++;
            $display("FAIL %s_start: done/err/pen/wr got %b want 0011", name, {cfg_done_o, err_o, bus.penable_o, bus.pwrite_o});
        end
        cyc = 0;
        hi = 0;
        first_hi = 0;
        while (!cfg_done_o && cyc < 400) begin
            if (bus.penable_o) hi++;
            if (hang && !bus.penable_o) begin
                first_hi = hi;
                hang = 1'b0;
                tests++;
                if (err_o !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_tmo_err: err got %b want 1", name, err_o);
                end
            end
            @(negedge pclk_i);
            cyc++;
        end
        tests++;
        if (cyc != (hang_first ? 3*NP - 1 + TO - 2 : 3*NP - 1)) begin
            fails++;
            $display("FAIL %s_done_cycles: got %0d want %0d", name, cyc, hang_first ? 3*NP - 1 + TO - 2 : 3*NP - 1);
        end
        tests++;
        if (hi != (hang_first ? TO + 2*(NP - 1) : 2*NP)) begin
            fails++;
            $display("FAIL %s_penable_cycles: got %0d want %0d", name, hi, hang_first ? TO + 2*(NP - 1) : 2*NP);
        end
        if (hang_first) begin
            tests++;
            if (first_hi != TO) begin
                fails++;
                $display("FAIL %s_tmo_len: got %0d want %0d", name, first_hi, TO);
            end
        end
        tests++;
        if (err_o !== hang_first) begin
            fails++;
            $display("FAIL %s_err: got %b want %b", name, err_o, hang_first);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s_xfer_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s_write: got w/a/d %0h want %0h", name, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // One interrupt through read-back, service dwell, pulse and drain.
    task automatic run_intr(input string name, input logic [PI-1:0] id, input bit hold,
                            input bit with_cfg, input logic [15:0] exp_cnt);
        int cyc;
        bit noisy;
        logic [PI-1:0] exp_prio;
        logic [2*PI:0] e;
        logic [2*PI:0] o;
        logic [NP-1:0] ea;
        logic [NP-1:0] oa;
        exp_prio = PI'(NP - 1) - id;
        exp_q.push_back({1'b0, id, exp_prio});
        exp_ack_q.push_back(NP'(1) << id);
        @(negedge pclk_i);
        bus.intr_valid_i = 1'b1;
        bus.intr_to_service_i = id;
        cfg_start_i = with_cfg;
        @(negedge pclk_i);
        cfg_start_i = 1'b0;
        tests++;
        if ({bus.penable_o, bus.pwrite_o, bus.paddr_o} !== {2'b10, id}) begin
            fails++;
            $display("FAIL %s_rd_issue: got %0h want %0h", name, {bus.penable_o, bus.pwrite_o, bus.paddr_o}, {2'b10, id});
        end
        cyc = 0;
        while (!(bus.penable_o && bus.pready_i) && cyc < 40) begin
            @(negedge pclk_i);
            cyc++;
        end
        @(negedge pclk_i);
        cyc = 0;
        while (!bus.intr_serviced_o && cyc < 40) begin
            @(negedge pclk_i);
            cyc++;
        end
        tests++;
        if (cyc != SC) begin
            fails++;
            $display("FAIL %s_svc_latency: got %0d want %0d", name, cyc, SC);
        end
        tests++;
        if ({last_intr_o, last_prio_o, svc_count_o} !== {id, exp_prio, exp_cnt}) begin
            fails++;
            $display("FAIL %s_status: got %0h want %0h", name, {last_intr_o, last_prio_o, svc_count_o}, {id, exp_prio, exp_cnt});
        end
        if (!hold) bus.intr_valid_i = 1'b0;
        @(negedge pclk_i);
        bus.intr_valid_i = 1'b0;
        tests++;
        if ({bus.intr_serviced_o, bus.intr_ack_o} !== '0) begin
            fails++;
            $display("FAIL %s_pulse_len: got %0h want 0", name, {bus.intr_serviced_o, bus.intr_ack_o});
        end
        noisy = 1'b0;
        repeat (6) begin
            @(negedge pclk_i);
            if (bus.penable_o || bus.intr_serviced_o) noisy = 1'b1;
        end
        tests++;
        if (noisy || svc_count_o !== exp_cnt) begin
            fails++;
            $display("FAIL %s_no_reservice: activity %b count got %0d want %0d", name, noisy, svc_count_o, exp_cnt);
        end
        tests++;
        if (obs_q.size() != exp_q.size() || ack_q.size() != exp_ack_q.size()) begin
            fails++;
            $display("FAIL %s_sb_count: xfers got %0d want %0d acks got %0d want %0d",
                     name, obs_q.size(), exp_q.size(), ack_q.size(), exp_ack_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s_read: got w/a/d %0h want %0h", name, o, e);
            end
        end
        while (exp_ack_q.size() > 0 && ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front();
            oa = ack_q.pop_front();
            tests++;
            if (oa !== ea) begin
                fails++;
                $display("FAIL %s_ack: got %0h want %0h", name, oa, ea);
            end
        end
        exp_q.delete();
        obs_q.delete();
        exp_ack_q.delete();
        ack_q.delete();
    endtask

    task automatic test_config();
        cfg_pass("cfg", 1'b0);
    endtask

    task automatic test_service();
        run_intr("svc5", 4'd5, 1'b1, 1'b0, 16'd1);
    endtask

    task automatic test_back_to_back();
        run_intr("svc9", 4'd9, 1'b0, 1'b0, 16'd2);
    endtask

    task automatic test_timeout();
        cfg_pass("tmo", 1'b1);
        cfg_pass("recfg", 1'b0);
    endtask

    task automatic test_cfg_vs_intr();
        run_intr("race", 4'd12, 1'b0, 1'b1, 16'd3);
        tests++;
        if (cfg_done_o !== 1'b1) begin
            fails++;
            $display("FAIL race_cfg_done: got %b want 1", cfg_done_o);
        end
    endtask

    task automatic test_reset_service();
        int cyc;
        bit active;
        @(negedge pclk_i);
        bus.intr_valid_i = 1'b1;
        bus.intr_to_service_i = 4'd7;
        cyc = 0;
        while (!(bus.penable_o && bus.pready_i) && cyc < 40) begin
            @(negedge pclk_i);
            cyc++;
        end
        repeat (2) @(negedge pclk_i);
        #2 prst_i = 1'b0;
        #1;
        tests++;
        if ({bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.intr_serviced_o, bus.intr_ack_o} !== '0) begin
            fails++;
            $display("FAIL rst_mid_bus: got %0h want 0",
                     {bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.intr_serviced_o, bus.intr_ack_o});
        end
        tests++;
        if ({cfg_done_o, last_intr_o, last_prio_o, svc_count_o, err_o} !== '0) begin
            fails++;
            $display("FAIL rst_mid_status: got %0h want 0", {cfg_done_o, last_intr_o, last_prio_o, svc_count_o, err_o});
        end
        @(negedge pclk_i);
        prst_i = 1'b1;
        active = 1'b0;
        repeat (10) begin
            @(negedge pclk_i);
            if (bus.penable_o || bus.intr_serviced_o) active = 1'b1;
        end
        tests++;
        if (active || svc_count_o !== 16'd0 || cfg_done_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle: activity %b count got %0d done got %b want 0/0/0", active, svc_count_o, cfg_done_o);
        end
        bus.intr_valid_i = 1'b0;
        obs_q.delete();
        ack_q.delete();
    endtask

    initial begin
        test_reset();
        test_config();
        test_service();
        test_back_to_back();
        test_timeout();
        test_cfg_vs_intr();
        test_reset_service();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
